// File: rtl/result_tx_serializer.sv
// Serialises a latched DATA_W-bit result to a UART Tx core one character at a time,
// as ASCII hex or raw bytes, with a one-deep pending buffer and an optional terminator.
module result_tx_serializer #(
  parameter int         DATA_W    = 32,
  parameter int         ASCII_HEX = 1,
  parameter int         LSB_FIRST = 0,
  parameter int         TERM_EN   = 1,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              new_result,
  input  logic              tx_done,
  output logic [7:0]        out_data,
  output logic              tx_start,
  output logic              data_done,
  output logic              busy,
  output logic              overrun
);

  localparam int CHAR_BITS = (ASCII_HEX != 0) ? 4 : 8;
  localparam int N_CHARS   = DATA_W / CHAR_BITS;
  localparam int CNT_W     = $clog2(N_CHARS + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, TSEND, TWAIT, FIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] pend_data;
  logic              pend_valid;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        char_raw;
  logic [7:0]        char_enc;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // The outgoing character always sits at the end of the shift register facing the UART.
  always_comb begin
    char_raw = (LSB_FIRST != 0) ? shreg[7:0] : shreg[DATA_W-1 -: 8];
    if (ASCII_HEX != 0)
      char_enc = hex_char((LSB_FIRST != 0) ? char_raw[3:0] : char_raw[7:4]);
    else
      char_enc = char_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_data   <= '0;
      tx_start   <= 1'b0;
      data_done  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      data_done <= 1'b0;
      overrun   <= 1'b0;
      busy      <= (state != IDLE);

      // Arrivals during a frame go to the pending slot, or are dropped if it is full.
      if (new_result && state != IDLE) begin
        if (!pend_valid) begin
          pend_data  <= in_data;
          pend_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          cnt <= CNT_W'(N_CHARS);
          if (pend_valid) begin
            shreg <= pend_data;
            state <= SEND;
            if (new_result)
              pend_data <= in_data;
            else
              pend_valid <= 1'b0;
          end else if (new_result) begin
            shreg <= in_data;
            state <= SEND;
          end
        end
        SEND: begin
          out_data <= char_enc;
          tx_start <= 1'b1;
          cnt      <= cnt - 1'b1;
          shreg    <= (LSB_FIRST != 0) ? (shreg >> CHAR_BITS) : (shreg << CHAR_BITS);
          state    <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            if (cnt != '0)
              state <= SEND;
            else if (TERM_EN != 0)
              state <= TSEND;
            else
              state <= FIN;
          end
        end
        TSEND: begin
          out_data <= TERM_CHAR;
          tx_start <= 1'b1;
          state    <= TWAIT;
        end
        TWAIT: begin
          if (tx_done)
            state <= FIN;
        end
        FIN: begin
          data_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_tx_serializer.sv
// Bench for result_tx_serializer: a default hex/MSB/terminated instance and a
// 16-bit raw/LSB/unterminated instance, each driven by a simple UART responder.
module tb_result_tx_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data_a;
  logic        new_result_a, tx_done_a;
  logic [7:0]  out_data_a;
  logic        tx_start_a, data_done_a, busy_a, overrun_a;
  logic [15:0] in_data_b;
  logic        new_result_b, tx_done_b;
  logic [7:0]  out_data_b;
  logic        tx_start_b, data_done_b, busy_b, overrun_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dly_a = 5, dly_b = 3;
  bit hold_a = 0;

  logic [7:0] q_a[$], q_b[$];
  int ts_a[$], dc_a[$], dc_b[$];
  int done_a = 0, done_b = 0, ovr_a = 0, ovr_b = 0;
  int last_td_a = 0, last_td_b = 0;

  always #5 clk = ~clk;

  result_tx_serializer dut_a (
    .clk(clk), .reset(reset), .in_data(in_data_a), .new_result(new_result_a),
    .tx_done(tx_done_a), .out_data(out_data_a), .tx_start(tx_start_a),
    .data_done(data_done_a), .busy(busy_a), .overrun(overrun_a)
  );

  result_tx_serializer #(.DATA_W(16), .ASCII_HEX(0), .LSB_FIRST(1), .TERM_EN(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data_b), .new_result(new_result_b),
    .tx_done(tx_done_b), .out_data(out_data_b), .tx_start(tx_start_b),
    .data_done(data_done_b), .busy(busy_b), .overrun(overrun_b)
  );

  // Output monitor, sampling just after each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (tx_start_a === 1'b1) begin q_a.push_back(out_data_a); ts_a.push_back(cyc); end
    if (tx_done_a === 1'b1) last_td_a = cyc;
    if (data_done_a === 1'b1) begin done_a++; dc_a.push_back(cyc); end
    if (overrun_a === 1'b1) ovr_a++;
    if (tx_start_b === 1'b1) q_b.push_back(out_data_b);
    if (tx_done_b === 1'b1) last_td_b = cyc;
    if (data_done_b === 1'b1) begin done_b++; dc_b.push_back(cyc); end
    if (overrun_b === 1'b1) ovr_b++;
  end

  // UART responders: one-cycle tx_done a fixed delay after each tx_start, or held high.
  initial begin
    tx_done_a = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_a) tx_done_a = 1'b1;
      else if (tx_start_a === 1'b1) begin
        tx_done_a = 1'b0;
        repeat (dly_a) @(negedge clk);
        tx_done_a = 1'b1;
        @(negedge clk);
        tx_done_a = 1'b0;
      end else tx_done_a = 1'b0;
    end
  end

  initial begin
    tx_done_b = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start_b === 1'b1) begin
        repeat (dly_b) @(negedge clk);
        tx_done_b = 1'b1;
        @(negedge clk);
        tx_done_b = 1'b0;
      end else tx_done_b = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Reference: each nibble written as a hex digit, most significant first, then newline.
  function automatic logic [71:0] hex_frame(input logic [31:0] v);
    logic [71:0] f = '0;
    for (int i = 0; i < 8; i++) begin
      int d = int'((v >> (28 - 4 * i)) & 32'hF);
      int c = (d < 10) ? (48 + d) : (65 + d - 10);
      f = {f[63:0], c[7:0]};
    end
    return {f[63:0], 8'h0A};
  endfunction

  // Reference: bytes least significant first, no terminator.
  function automatic logic [15:0] raw_frame(input logic [15:0] v);
    logic [15:0] f = '0;
    for (int i = 0; i < 2; i++) begin
      int c = int'((v >> (8 * i)) & 16'hFF);
      f = {f[7:0], c[7:0]};
    end
    return f;
  endfunction

  task automatic wait_q_a(input int n, input string nm);
    for (int i = 0; i < 800; i++) begin
      if (q_a.size() >= n) return;
      @(negedge clk);
    end
    timeout_fail(nm);
  endtask

  task automatic wait_done_a(input int n, input string nm);
    for (int i = 0; i < 1500; i++) begin
      if (done_a >= n) return;
      @(negedge clk);
    end
    timeout_fail(nm);
  endtask

  task automatic run_a(input logic [31:0] v, input bit chk_t, output logic [71:0] frame,
                       output int n);
    int d0, c0;
    q_a.delete(); ts_a.delete(); dc_a.delete();
    d0 = done_a;
    @(negedge clk);
    in_data_a = v; new_result_a = 1'b1; c0 = cyc;
    @(negedge clk);
    new_result_a = 1'b0;
    if (chk_t) chk("a_busy_edge_k", busy_a, 0);
    @(negedge clk);
    if (chk_t) chk("a_busy_edge_k1", busy_a, 1);
    wait_done_a(d0 + 1, "a_frame_done");
    repeat (3) @(negedge clk);
    frame = '0;
    foreach (q_a[i]) frame = {frame[63:0], q_a[i]};
    n = q_a.size();
    chk("a_busy_after", busy_a, 0);
    chk("a_done_count", done_a - d0, 1);
    if (chk_t && ts_a.size() > 0 && dc_a.size() > 0) begin
      chk("a_start_latency", ts_a[0] - c0, 2);
      chk("a_done_latency", dc_a[0] - last_td_a, 1);
    end
  endtask

  task automatic run_b(input logic [15:0] v, output logic [15:0] frame, output int n);
    int d0;
    q_b.delete(); dc_b.delete();
    d0 = done_b;
    @(negedge clk);
    in_data_b = v; new_result_b = 1'b1;
    @(negedge clk);
    new_result_b = 1'b0;
    for (int i = 0; i < 400 && done_b == d0; i++) @(negedge clk);
    if (done_b == d0) timeout_fail("b_frame_done");
    repeat (3) @(negedge clk);
    frame = '0;
    foreach (q_b[i]) frame = {frame[7:0], q_b[i]};
    n = q_b.size();
    chk("b_done_count", done_b - d0, 1);
    if (dc_b.size() > 0) chk("b_done_latency", dc_b[0] - last_td_b, 1);
  endtask

  typedef struct {
    logic [31:0] val;
    logic [71:0] exp;
    int          dly;
  } vec_t;

  initial begin
    vec_t        tbl[4];
    logic [71:0] fr;
    logic [15:0] frb;
    logic [31:0] rv;
    int          n, d0, o0;
    bit          ok;

    tbl[0] = '{32'h1234ABCD, "1234ABCD\n", 5};
    tbl[1] = '{32'h00000000, "00000000\n", 0};
    tbl[2] = '{32'hFFFFFFFF, "FFFFFFFF\n", 2};
    tbl[3] = '{32'h09AF5C3E, "09AF5C3E\n", 1};

    // Reset held with new_result asserted: everything quiet.
    reset = 1'b1;
    in_data_a = 32'hDEADBEEF; new_result_a = 1'b1;
    in_data_b = 16'h1234;     new_result_b = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_a", {out_data_a, tx_start_a, data_done_a, busy_a, overrun_a}, 0);
      chk("rst_out_b", {out_data_b, tx_start_b, data_done_b, busy_b, overrun_b}, 0);
    end
    reset = 1'b0; new_result_a = 1'b0; new_result_b = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_start_a", q_a.size(), 0);
    chk("rst_no_start_b", q_b.size(), 0);

    foreach (tbl[i]) begin
      dly_a = tbl[i].dly;
      run_a(tbl[i].val, 1'b1, fr, n);
      chk("tbl_nchars", n, 9);
      chk("tbl_frame", fr, tbl[i].exp);
    end

    dly_b = 4;
    run_b(16'hBEEF, frb, n);
    chk("b_beef_nchars", n, 2);
    chk("b_beef_frame", frb, 16'hEFBE);

    // tx_done held high: one char per two cycles, nothing skipped.
    hold_a = 1'b1;
    run_a(32'h5A3C0F96, 1'b0, fr, n);
    hold_a = 1'b0;
    chk("hold_nchars", n, 9);
    chk("hold_frame", fr, hex_frame(32'h5A3C0F96));
    ok = 1'b1;
    for (int i = 1; i < ts_a.size(); i++) if (ts_a[i] - ts_a[i-1] != 2) ok = 1'b0;
    chk("hold_spacing", ok, 1);
    repeat (3) @(negedge clk);

    // Mid-frame arrivals, then a new result in the IDLE cycle that consumes pending.
    dly_a = 3;
    q_a.delete(); ts_a.delete(); dc_a.delete();
    d0 = done_a; o0 = ovr_a;
    @(negedge clk); in_data_a = 32'hCAFE0123; new_result_a = 1'b1;
    @(negedge clk); new_result_a = 1'b0;
    wait_q_a(2, "mid_second_char");
    in_data_a = 32'h00000001; new_result_a = 1'b1;
    @(negedge clk); in_data_a = 32'h00000002;
    @(negedge clk); new_result_a = 1'b0;
    wait_done_a(d0 + 1, "mid_first_done");
    in_data_a = 32'h00000003; new_result_a = 1'b1;
    @(negedge clk); new_result_a = 1'b0;
    wait_done_a(d0 + 3, "mid_all_done");
    repeat (60) @(negedge clk);
    chk("mid_nchars", q_a.size(), 27);
    chk("mid_overruns", ovr_a - o0, 1);
    chk("mid_frames", done_a - d0, 3);
    if (q_a.size() == 27) begin
      for (int f = 0; f < 3; f++) begin
        fr = '0;
        for (int i = 0; i < 9; i++) fr = {fr[63:0], q_a[9*f + i]};
        chk("mid_frame", fr, hex_frame((f == 0) ? 32'hCAFE0123 :
                                       (f == 1) ? 32'h00000001 : 32'h00000003));
      end
      if (dc_a.size() > 0) chk("mid_pend_gap", ts_a[9] - dc_a[0], 2);
    end

    // Reset mid-frame with a pending result: frame and pending both abandoned.
    q_a.delete(); d0 = done_a;
    @(negedge clk); in_data_a = 32'h55AA33CC; new_result_a = 1'b1;
    @(negedge clk); new_result_a = 1'b0;
    wait_q_a(1, "rst_mid_first");
    in_data_a = 32'h00000077; new_result_a = 1'b1;
    @(negedge clk); new_result_a = 1'b0;
    wait_q_a(3, "rst_mid_third");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {out_data_a, tx_start_a, busy_a, data_done_a}, 0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_mid_no_more", q_a.size(), 3);
    chk("rst_mid_no_done", done_a - d0, 0);
    run_a(32'h13579BDF, 1'b1, fr, n);
    chk("rst_mid_after", fr, hex_frame(32'h13579BDF));
    repeat (40) @(negedge clk);
    chk("rst_mid_single", q_a.size(), 9);

    // Randomized frames against the reference encoders.
    for (int k = 0; k < 8; k++) begin
      rv = $urandom;
      dly_a = $urandom_range(0, 6);
      run_a(rv, 1'b1, fr, n);
      chk("rand_a_nchars", n, 9);
      chk("rand_a_frame", fr, hex_frame(rv));
    end
    for (int k = 0; k < 8; k++) begin
      rv = $urandom;
      dly_b = $urandom_range(0, 6);
      run_b(rv[15:0], frb, n);
      chk("rand_b_nchars", n, 2);
      chk("rand_b_frame", frb, raw_frame(rv[15:0]));
    end
    chk("b_no_overrun", ovr_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
